// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int FRAME_W = 32;
  localparam int DIGITS  = 8;

  localparam logic [FRAME_W-1:0] BLANK_FRAME = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  // Walk the ring starting at ptr; the first hit wins.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 8-digit display with min/max hold and a blank gap
// between owners. Frame and blank mask are registered toward the scanner.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MIN_HOLD = 50_000_000,
  parameter int MAX_HOLD = 200_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [FRAME_W*NREQ-1:0] frame_in,
  input  logic                    lz_en,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [FRAME_W-1:0]      disp_data,
  output logic [DIGITS-1:0]       disp_blank
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MIN_LIM = HW'(MIN_HOLD - 1);
  localparam logic [HW-1:0] MAX_LIM = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] SAT     = HW'(MAX_HOLD);

  // Blank a digit when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [FRAME_W-1:0] f);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_above = zero_above & (f[4*d +: 4] == 4'h0);
      m[d]       = zero_above;
    end
    return m;
  endfunction

  state_t             state, state_nx;
  logic [IW-1:0]      owner, owner_nx, ptr, ptr_nx, pick_idx, ptr_after;
  logic [HW-1:0]      hold_cnt, hold_nx;
  logic [NREQ-1:0]    gnt_nx, pick_gnt;
  logic               busy_nx, pick_any, rel_cond, pre_cond;
  logic [FRAME_W-1:0] data_nx, sel_frame;
  logic [DIGITS-1:0]  blank_nx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_frame = frame_in[FRAME_W*owner +: FRAME_W];
  // gnt is one-hot on owner while in OWN, so it masks the owner out of req.
  assign rel_cond  = !req[owner] && (hold_cnt >= MIN_LIM);
  assign pre_cond  = (hold_cnt >= MAX_LIM) && |(req & ~gnt);
  assign ptr_after = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

  // Next-state and next-output decode; everything holds unless a branch changes it.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    gnt_nx   = gnt;
    busy_nx  = busy;
    data_nx  = disp_data;
    blank_nx = disp_blank;
    case (state)
      IDLE, GAP: begin
        state_nx = IDLE;
        if (pick_any) begin
          state_nx = OWN;
          owner_nx = pick_idx;
          gnt_nx   = pick_gnt;
          busy_nx  = 1'b1;
          hold_nx  = '0;
        end
      end
      OWN: begin
        // Release and preemption lead to the same GAP entry and pointer
        // update, so the two need no separate priority.
        if (rel_cond || pre_cond) begin
          state_nx = GAP;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
          hold_nx  = '0;
          ptr_nx   = ptr_after;
          data_nx  = BLANK_FRAME;
          blank_nx = '1;
        end else begin
          if (hold_cnt != SAT) hold_nx = hold_cnt + 1'b1;
          if (req[owner]) begin
            data_nx  = sel_frame;
            blank_nx = lz_en ? lz_mask(sel_frame) : '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        data_nx  = BLANK_FRAME;
        blank_nx = '1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      disp_data  <= BLANK_FRAME;
      disp_blank <= '1;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      ptr        <= ptr_nx;
      hold_cnt   <= hold_nx;
      gnt        <= gnt_nx;
      busy       <= busy_nx;
      disp_data  <= data_nx;
      disp_blank <= blank_nx;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter; tenure scoreboard plus point checks.
module tb_seg_display_arbiter;

  localparam int NREQ     = 4;
  localparam int MIN_HOLD = 4;
  localparam int MAX_HOLD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] frame_in = '0;
  logic         lz_en = 1'b1;
  logic [3:0]   gnt;
  logic         busy;
  logic [31:0]  disp_data;
  logic [7:0]   disp_blank;

  seg_display_arbiter #(.NREQ(NREQ), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .frame_in   (frame_in),
    .lz_en      (lz_en),
    .gnt        (gnt),
    .busy       (busy),
    .disp_data  (disp_data),
    .disp_blank (disp_blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    int         len;
  } ten_t;

  ten_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] cur_g = '0;
  int         run = 0;
  logic [3:0] rr_seq [0:4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input int len);
    ten_t e;
    e.g   = g;
    e.len = len;
    sb.push_back(e);
  endtask

  // Per-cycle invariants, and tenure scoring when a grant run ends.
  task automatic monitor();
    chk("busy_vs_gnt", 32'(busy), 32'(gnt != 4'b0));
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
    if (gnt !== cur_g) begin
      if (cur_g != 4'b0) begin
        if (sb.size() == 0) chk("sb_extra", 32'(cur_g), 32'd0);
        else begin
          ten_t e;
          e = sb.pop_front();
          chk("ten_gnt", 32'(cur_g), 32'(e.g));
          chk("ten_len", 32'(run), 32'(e.len));
        end
      end
      cur_g = gnt;
      run   = (gnt != 4'b0) ? 1 : 0;
    end else if (gnt != 4'b0) begin
      run++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  initial begin
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset and idle
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", disp_data, 32'hFFFF_FFFF);
    chk("rst_blank", 32'(disp_blank), 32'hFF);
    rst = 1'b1;
    repeat (10) tick();
    chk("idle_data", disp_data, 32'hFFFF_FFFF);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // single requester, frame load with leading-zero mask, minimum tenure
    frame_in[64 +: 32] = 32'h0000_0123;
    req = 4'b0100;
    push(4'b0100, 4);
    tick();
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_data_pre", disp_data, 32'hFFFF_FFFF);
    tick();
    chk("t2_data", disp_data, 32'h0000_0123);
    chk("t2_blank", 32'(disp_blank), 32'hF8);
    req = 4'b0000;
    repeat (2) tick();
    chk("t2_frozen", disp_data, 32'h0000_0123);
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    chk("t2_gap_data", disp_data, 32'hFFFF_FFFF);
    chk("t2_gap_blank", 32'(disp_blank), 32'hFF);
    tick();
    chk("t2_idle", 32'(busy), 32'd0);

    // one-cycle pulse still holds for MIN_HOLD, frame never loaded
    req = 4'b0100;
    push(4'b0100, 4);
    tick();
    chk("p_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    repeat (3) tick();
    chk("p_busy", 32'(busy), 32'd1);
    chk("p_frozen", disp_data, 32'hFFFF_FFFF);
    tick();
    chk("p_gap", 32'(busy), 32'd0);
    tick();
    chk("p_idle", 32'(gnt), 32'd0);

    // reset pointer, then all requesters: max-hold preemption in ring order
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) push(rr_seq[k], 16);
    tick();
    chk("rr_first", 32'(gnt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      repeat (15) tick();
      chk("rr_hold", 32'(gnt), 32'(rr_seq[k]));
      tick();
      chk("rr_gap", 32'(gnt), 32'd0);
      tick();
      chk("rr_next", 32'(gnt), 32'(rr_seq[k+1]));
    end

    // owner 0 releases early; owner 1 drops req exactly at the preempt point
    req = 4'b1010;
    push(4'b0001, 4);
    repeat (4) tick();
    chk("rel_gap", 32'(gnt), 32'd0);
    tick();
    chk("rel_next", 32'(gnt), 32'h2);
    push(4'b0010, 16);
    repeat (15) tick();
    chk("both_hold", 32'(gnt), 32'h2);
    req = 4'b1000;
    tick();
    chk("both_gap", 32'(gnt), 32'd0);
    tick();
    chk("both_next", 32'(gnt), 32'h8);

    // lone owner past MAX_HOLD, all-zero frame and mask variants
    push(4'b1000, 34);
    repeat (30) tick();
    chk("sat_gnt", 32'(gnt), 32'h8);
    chk("sat_data", disp_data, 32'h0);
    chk("sat_blank", 32'(disp_blank), 32'hFE);
    frame_in[96 +: 32] = 32'h0000_0042;
    lz_en = 1'b0;
    tick();
    chk("nolz_data", disp_data, 32'h0000_0042);
    chk("nolz_blank", 32'(disp_blank), 32'h00);
    lz_en = 1'b1;
    tick();
    chk("lz_blank", 32'(disp_blank), 32'hFC);
    frame_in[96 +: 32] = 32'hA000_0000;
    tick();
    chk("af_data", disp_data, 32'hA000_0000);
    chk("af_blank", 32'(disp_blank), 32'h00);

    // reset mid-OWN, then arbitration restarts from pointer 0
    rst = 1'b0;
    tick();
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_data", disp_data, 32'hFFFF_FFFF);
    chk("mr_blank", 32'(disp_blank), 32'hFF);
    rst = 1'b1;
    req = 4'b1010;
    push(4'b0010, 4);
    tick();
    chk("ptr0_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    repeat (6) tick();
    chk("end_gnt", 32'(gnt), 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single 8-digit seven-segment display between up to NREQ independent requesters (counters, status readouts, debug views). Performs round-robin arbitration with minimum and maximum hold times and inserts a one-cycle blank gap between owners. Outputs a registered 8-digit BCD frame plus a per-digit blank mask to the existing scan/decode block, which owns digit multiplexing and segment encoding.

## Interface
- NREQ, 4: number of requesters, 2..8.
- MIN_HOLD, 50_000_000: minimum cycles an owner keeps the display.
- MAX_HOLD, 200_000_000: cycles after which an owner is preempted if another requester waits; MAX_HOLD > MIN_HOLD.
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-low reset.
- req  in  NREQ  level request per requester.
- frame_in  in  32*NREQ  requester i's frame at bits [32i+31:32i]; digit d at [4d+3:4d]; digit 0 is rightmost.
- lz_en  in  1  leading-zero suppression enable.
- gnt  out  NREQ  registered one-hot grant; all-zero when no owner.
- busy  out  1  registered; 1 while in OWN.
- disp_data  out  32  registered frame to the scanner.
- disp_blank  out  8  registered; bit d = 1 blanks digit d.

## Operation
- States: IDLE, OWN, GAP.
- IDLE: gnt=0, disp_data=32'hFFFF_FFFF, disp_blank=8'hFF. If any req, pick the winner with the round-robin picker starting at ptr, load owner, then go to OWN.
- OWN: hold_cnt increments each cycle from 0 and saturates at MAX_HOLD. While req[owner]=1, disp_data <= owner's frame every cycle. While req[owner]=0, the frame stays frozen.
- OWN -> GAP on either of two conditions:
  - Release: req[owner]=0 and hold_cnt >= MIN_HOLD-1.
  - Preemption: hold_cnt >= MAX_HOLD-1 and any other req bit is set.
- If both conditions hold in the same cycle, the transition is a release. Either way, ptr <= (owner+1) mod NREQ.
- GAP, exactly 1 cycle: gnt=0, disp_data all F, disp_blank=8'hFF. Then arbitrate from ptr; go to OWN if any req, else to IDLE.
- Owner holding past MAX_HOLD with no competitor: stays in OWN indefinitely; hold_cnt saturates.
- Round-robin: the picker searches ptr, ptr+1, ... with wrap, so the preempted or released owner has lowest priority next.
- Blank mask in OWN:
  - With lz_en=1, disp_blank[d]=1 iff digit d and all higher digits of the latched frame are 0. Digit 0 is never blanked.
  - With lz_en=0, disp_blank=0.
  - The mask is computed from the value being loaded, so it is always consistent with disp_data.
- Digits 4'hA..4'hF pass through unchanged; the scanner renders them blank.
- hold_cnt width is $clog2(MAX_HOLD+1).

## Timing
- Reset (rst=0 at a clk edge): state=IDLE, gnt=0, busy=0, ptr=0, owner=0, hold_cnt=0, disp_data=32'hFFFF_FFFF, disp_blank=8'hFF. Reset mid-OWN takes effect at that edge.
- From IDLE, req rises before edge t: gnt and busy are valid after edge t. disp_data carries the owner's frame_in sampled at edge t+1, so request to visible frame is 2 edges.
- Release/preempt decision at edge t: gnt=0 after t (GAP). The new gnt appears after t+1, and the new frame after t+2.
- Minimum owner tenure is MIN_HOLD cycles of busy=1, even if req drops immediately.
- gnt never has more than one bit set, and gnt=0 whenever busy=0.

## Structure
- Package seg_disp_pkg holds:
  - state enum (IDLE, OWN, GAP)
  - FRAME_W=32, DIGITS=8
  - BLANK_FRAME=32'hFFFF_FFFF
- Sub-module rr_pick: combinational round-robin picker with req and ptr in, one-hot grant and index out, parameter NREQ.
- Leading-zero mask logic lives in this block as a function.

## Test plan
Bench parameters: NREQ=4, MIN_HOLD=4, MAX_HOLD=16.
- Reset then idle: all outputs at reset values; after 10 cycles still disp_data=FFFF_FFFF, gnt=0.
- req=4'b0100, frame_in[2]=32'h0000_0123, lz_en=1:
  - gnt=4'b0100 one edge later.
  - Next edge: disp_data=32'h0000_0123, disp_blank=8'b1111_1000.
- req[2] pulsed for 1 cycle: busy stays 1 for exactly 4 cycles with the frozen frame, then GAP for 1 cycle, then IDLE.
- req=4'b1111 held:
  - Grants go in order 0,1,2,3,0.
  - Each tenure is 16 cycles, with one blank GAP cycle between tenures.
- Owner 1 drops req in the same cycle hold_cnt reaches 15 while req[3]=1: treated as release; next grant is 4'b1000.
- rst asserted mid-OWN: gnt=0 and disp_data=FFFF_FFFF after that edge. After release, arbitration restarts from ptr=0.
